// File: rtl/aes_cp_pkg.sv
// Shared definitions for the AES copy-engine sequencer.
package aes_cp_pkg;

  localparam int unsigned BLK_MAX       = 128;
  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned BYTES_PER_BLK = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    REQ  = 3'd3,
    WAIT = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } cpState_e;

endpackage

// File: rtl/aes_cp_ctrl.sv
// Copy-engine sequencer: InBuf -> AES core -> OutBuf, one 128-bit block at a time.
module aes_cp_ctrl #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned SIZE_W  = 12,
  parameter int unsigned BLK_MAX = 128
) (
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iStCp,
  input  logic [SIZE_W-1:0] iCpByteSize,
  output logic              oCpDone,
  output logic              oBusy,
  output logic              oRdEn_InBuf,
  output logic [ADDR_W-1:0] oRdAddr_InBuf,
  input  logic [31:0]       iRdDt_InBuf,
  output logic              oAesStart,
  output logic [127:0]      oAesDt,
  input  logic              iAesDone,
  input  logic [127:0]      iAesDt,
  output logic              oWrEn_OutBuf,
  output logic [ADDR_W-1:0] oWrAddr_OutBuf,
  output logic [31:0]       oWrDt_OutBuf
);

  import aes_cp_pkg::*;

  localparam int unsigned SUB_W  = $clog2(WORDS_PER_BLK);
  localparam int unsigned BLK_SH = $clog2(BYTES_PER_BLK);
  localparam int unsigned CNT_W  = $clog2(BLK_MAX + 1);
  localparam int unsigned RAW_W  = SIZE_W + 1;
  localparam int unsigned IDX_W  = CNT_W + SUB_W;

  cpState_e          state;
  logic [CNT_W-1:0]  blkIdx;
  logic [CNT_W-1:0]  blkNum;
  logic [CNT_W-1:0]  blkNumNext;
  logic [CNT_W-1:0]  blkIdxInc;
  logic [SUB_W-1:0]  subCnt;
  logic              subLast;
  logic [95:0]       shiftReg;
  logic [127:0]      aesDtReg;
  logic [127:0]      resReg;
  logic [RAW_W-1:0]  rawBlk;
  logic [IDX_W-1:0]  wordIdx;

  // Block count from the byte size: round up to whole blocks, then clamp.
  always_comb begin
    rawBlk     = ({1'b0, iCpByteSize} + RAW_W'(BYTES_PER_BLK - 1)) >> BLK_SH;
    blkNumNext = (rawBlk > RAW_W'(BLK_MAX)) ? CNT_W'(BLK_MAX) : CNT_W'(rawBlk);
  end

  assign subLast   = (subCnt == '1);
  assign blkIdxInc = blkIdx + CNT_W'(1);
  assign wordIdx   = {blkIdx, subCnt};

  // Sequencer state, counters and block pack/unpack registers.
  // InBuf data lags the address by one cycle, so words 0..2 shift in during
  // RD sub-counts 1..3 and word 3 arrives directly in CAP.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state    <= IDLE;
      blkIdx   <= '0;
      blkNum   <= '0;
      subCnt   <= '0;
      shiftReg <= '0;
      aesDtReg <= '0;
      resReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStCp) begin
            blkNum <= blkNumNext;
            blkIdx <= '0;
            subCnt <= '0;
            state  <= (blkNumNext == '0) ? DONE : RD;
          end
        end
        RD: begin
          if (subCnt != '0) shiftReg <= {shiftReg[63:0], iRdDt_InBuf};
          subCnt <= subCnt + SUB_W'(1);
          if (subLast) state <= CAP;
        end
        CAP: begin
          aesDtReg <= {shiftReg, iRdDt_InBuf};
          state    <= REQ;
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (iAesDone) begin
            resReg <= iAesDt;
            state  <= WR;
          end
        end
        WR: begin
          subCnt <= subCnt + SUB_W'(1);
          if (subLast) begin
            blkIdx <= blkIdxInc;
            state  <= (blkIdxInc < blkNum) ? RD : DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    oBusy          = (state != IDLE);
    oCpDone        = (state == DONE);
    oAesStart      = (state == REQ);
    oRdEn_InBuf    = (state == RD);
    oWrEn_OutBuf   = (state == WR);
    oRdAddr_InBuf  = '0;
    oWrAddr_OutBuf = '0;
    oWrDt_OutBuf   = '0;
    if (state == RD) oRdAddr_InBuf = ADDR_W'(wordIdx);
    if (state == WR) begin
      oWrAddr_OutBuf = ADDR_W'(wordIdx);
      case (subCnt)
        2'd0:    oWrDt_OutBuf = resReg[127:96];
        2'd1:    oWrDt_OutBuf = resReg[95:64];
        2'd2:    oWrDt_OutBuf = resReg[63:32];
        default: oWrDt_OutBuf = resReg[31:0];
      endcase
    end
  end

  assign oAesDt = aesDtReg;

endmodule

// File: tb/tb_aes_cp_ctrl.sv
// Self-checking bench for aes_cp_ctrl with InBuf/AES/OutBuf behavioural models.
module tb_aes_cp_ctrl;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned SIZE_W = 12;

  logic              iClk = 1'b0;
  logic              iRsn;
  logic              iStCp;
  logic [SIZE_W-1:0] iCpByteSize;
  logic              oCpDone;
  logic              oBusy;
  logic              oRdEn_InBuf;
  logic [ADDR_W-1:0] oRdAddr_InBuf;
  logic [31:0]       iRdDt_InBuf;
  logic              oAesStart;
  logic [127:0]      oAesDt;
  logic              iAesDone;
  logic [127:0]      iAesDt;
  logic              oWrEn_OutBuf;
  logic [ADDR_W-1:0] oWrAddr_OutBuf;
  logic [31:0]       oWrDt_OutBuf;

  aes_cp_ctrl #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .BLK_MAX(128)) dut (
    .iClk(iClk), .iRsn(iRsn), .iStCp(iStCp), .iCpByteSize(iCpByteSize),
    .oCpDone(oCpDone), .oBusy(oBusy),
    .oRdEn_InBuf(oRdEn_InBuf), .oRdAddr_InBuf(oRdAddr_InBuf), .iRdDt_InBuf(iRdDt_InBuf),
    .oAesStart(oAesStart), .oAesDt(oAesDt), .iAesDone(iAesDone), .iAesDt(iAesDt),
    .oWrEn_OutBuf(oWrEn_OutBuf), .oWrAddr_OutBuf(oWrAddr_OutBuf), .oWrDt_OutBuf(oWrDt_OutBuf)
  );

  always #5 iClk = ~iClk;

  int nCmp = 0;
  int nErr = 0;
  int cyc = 0;

  always @(posedge iClk) cyc <= cyc + 1;

  // Environment state
  logic [31:0]  inMem  [512];
  logic [31:0]  outMem [512];
  logic [127:0] ptSeen [$];
  logic         rdEnPrev = 1'b0;
  logic [ADDR_W-1:0] rdAddrPrev = '0;
  logic         modelDone = 1'b0;
  logic         strayDone = 1'b0;
  logic         pend = 1'b0;
  logic [127:0] aesIn = '0;
  int lat = 1, rCyc = 0;
  int rdCount, wrCount, rdNext, wrNext, rdBad, wrBad, starts, unstable;
  int doneCnt, doneCyc, lastWrAddr, tStart;

  assign iAesDone = modelDone | strayDone;

  // Stand-in for the AES core: any fixed bijection is enough to track data.
  function automatic logic [127:0] aesF(input logic [127:0] pt);
    return {pt[63:0], pt[127:64]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Models and monitors, evaluated mid-cycle where DUT outputs are settled.
  always @(negedge iClk) begin
    // InBuf: one-cycle read latency
    iRdDt_InBuf = rdEnPrev ? inMem[rdAddrPrev] : $urandom;
    rdEnPrev    = oRdEn_InBuf;
    rdAddrPrev  = oRdAddr_InBuf;
    if (oRdEn_InBuf) begin
      if (oRdAddr_InBuf != ADDR_W'(rdNext)) rdBad++;
      rdNext++;
      rdCount++;
    end
    // AES core: result L cycles after the request
    if (pend && oAesDt != aesIn) unstable++;
    if (pend && cyc == rCyc + lat) begin
      modelDone = 1'b1;
      iAesDt    = aesF(aesIn);
      pend      = 1'b0;
    end else begin
      modelDone = 1'b0;
      iAesDt    = {$urandom, $urandom, $urandom, $urandom};
    end
    if (oAesStart) begin
      pend  = 1'b1;
      rCyc  = cyc;
      aesIn = oAesDt;
      ptSeen.push_back(oAesDt);
      starts++;
    end
    // OutBuf
    if (oWrEn_OutBuf) begin
      outMem[oWrAddr_OutBuf] = oWrDt_OutBuf;
      if (oWrAddr_OutBuf != ADDR_W'(wrNext)) wrBad++;
      wrNext++;
      wrCount++;
      lastWrAddr = int'(oWrAddr_OutBuf);
    end
    if (oCpDone) begin
      doneCnt++;
      doneCyc = cyc;
    end
  end

  task automatic clearEnv(input bit randData);
    rdCount = 0; wrCount = 0; rdNext = 0; wrNext = 0; rdBad = 0; wrBad = 0;
    starts = 0; unstable = 0; doneCnt = 0; doneCyc = -1; lastWrAddr = -1;
    pend = 1'b0;
    ptSeen.delete();
    for (int i = 0; i < 512; i++) begin
      outMem[i] = '0;
      if (randData) inMem[i] = $urandom;
    end
  endtask

  // One complete copy with the reference expectations worked out from size and latency.
  task automatic runCopy(input int size, input int l, input bit strayStart,
                         input bit strayRd, input bit randData);
    int expN, budget, badData, badPt;
    bit injS, injR;
    logic [127:0] pt, ct;
    clearEnv(randData);
    lat  = l;
    expN = (size + 15) / 16;
    if (expN > 128) expN = 128;
    // a stray core pulse while idle must not wake the sequencer
    @(negedge iClk); #1;
    strayDone = 1'b1;
    @(negedge iClk); #1;
    strayDone = 1'b0;
    checkVal("idleStrayBusy", oBusy, 0);
    iCpByteSize = SIZE_W'(size);
    iStCp = 1'b1;
    tStart = cyc;
    @(negedge iClk); #1;
    iStCp = 1'b0;
    iCpByteSize = SIZE_W'($urandom);
    checkVal("busyRise", oBusy, 1);
    budget = 0;
    injS = strayStart;
    injR = strayRd;
    while (doneCnt == 0 && budget < 5000) begin
      if (injS && pend && cyc > rCyc) begin
        iStCp = 1'b1;
        iCpByteSize = SIZE_W'(320);
        injS = 1'b0;
      end else iStCp = 1'b0;
      if (injR && oRdEn_InBuf) begin
        strayDone = 1'b1;
        injR = 1'b0;
      end else strayDone = 1'b0;
      @(negedge iClk); #1;
      budget++;
    end
    iStCp = 1'b0;
    strayDone = 1'b0;
    checkVal("doneTimeout", budget < 5000, 1);
    checkVal("doneCycle", doneCyc - tStart, 1 + expN * (10 + l));
    @(negedge iClk); #1;
    checkVal("busyFall", oBusy, 0);
    repeat (3) @(negedge iClk);
    #1;
    checkVal("doneCount", doneCnt, 1);
    checkVal("aesStarts", starts, expN);
    checkVal("rdCount", rdCount, 4 * expN);
    checkVal("wrCount", wrCount, 4 * expN);
    checkVal("rdOrder", rdBad, 0);
    checkVal("wrOrder", wrBad, 0);
    checkVal("aesDtStable", unstable, 0);
    badData = 0;
    badPt = 0;
    for (int k = 0; k < expN; k++) begin
      pt = {inMem[4*k], inMem[4*k+1], inMem[4*k+2], inMem[4*k+3]};
      ct = aesF(pt);
      if (k >= ptSeen.size() || ptSeen[k] !== pt) badPt++;
      for (int j = 0; j < 4; j++)
        if (outMem[4*k+j] !== ct[127-32*j -: 32]) badData++;
    end
    checkVal("plaintext", badPt, 0);
    checkVal("outData", badData, 0);
    if (expN > 0) checkVal("lastWrAddr", lastWrAddr, 4 * expN - 1);
  endtask

  initial begin
    int sz, l, budget;
    iRsn = 1'b0;
    iStCp = 1'b0;
    iCpByteSize = '0;
    for (int i = 0; i < 512; i++) inMem[i] = '0;
    clearEnv(1'b0);
    repeat (2) @(negedge iClk);
    checkVal("resetOutputs",
             |{oCpDone, oBusy, oRdEn_InBuf, oRdAddr_InBuf, oAesStart, oAesDt,
               oWrEn_OutBuf, oWrAddr_OutBuf, oWrDt_OutBuf}, 0);
    iRsn = 1'b1;
    repeat (2) @(negedge iClk);

    // Known single block, L=3
    inMem[0] = 32'h00112233; inMem[1] = 32'h44556677;
    inMem[2] = 32'h8899AABB; inMem[3] = 32'hCCDDEEFF;
    runCopy(16, 3, 1'b0, 1'b0, 1'b0);
    checkVal("tp1AesDt", ptSeen.size() > 0 ? ptSeen[0] : '0,
             128'h00112233_44556677_8899AABB_CCDDEEFF);
    checkVal("tp1DoneAt", doneCyc - tStart, 14);
    checkVal("tp1Word0", outMem[0], 32'h8899AABB ^ 32'h0f1e2d3c);
    checkVal("tp1Word3", outMem[3], 32'h44556677 ^ 32'hc3d2e1f0);

    // Partial final block: 3 blocks
    runCopy(33, 2, 1'b0, 1'b0, 1'b1);
    // Empty copy
    runCopy(0, 2, 1'b0, 1'b0, 1'b1);
    // Clamp at 128 blocks, last address 0x1FF
    runCopy(4095, 2, 1'b0, 1'b0, 1'b1);
    checkVal("clampLastAddr", lastWrAddr, 511);
    // Start pulse during WAIT ignored; stray core pulse in RD ignored
    runCopy(40, 4, 1'b1, 1'b1, 1'b1);
    // Exact multiple and one-past boundaries
    runCopy(32, 1, 1'b0, 1'b0, 1'b1);
    runCopy(17, 1, 1'b0, 1'b0, 1'b1);

    // Reset during WR of block 1 of 3
    clearEnv(1'b1);
    lat = 2;
    @(negedge iClk); #1;
    iCpByteSize = SIZE_W'(48);
    iStCp = 1'b1;
    @(negedge iClk); #1;
    iStCp = 1'b0;
    budget = 0;
    while (!(oWrEn_OutBuf && oWrAddr_OutBuf >= 4 && oWrAddr_OutBuf <= 7) && budget < 200) begin
      @(negedge iClk); #1;
      budget++;
    end
    checkVal("rstReachWr", budget < 200, 1);
    iRsn = 1'b0;
    #1;
    checkVal("rstMidOutputs",
             |{oCpDone, oBusy, oRdEn_InBuf, oRdAddr_InBuf, oAesStart, oAesDt,
               oWrEn_OutBuf, oWrAddr_OutBuf, oWrDt_OutBuf}, 0);
    repeat (3) @(negedge iClk);
    #1;
    checkVal("rstNoDone", doneCnt, 0);
    iRsn = 1'b1;
    @(negedge iClk);
    runCopy(48, 2, 1'b0, 1'b0, 1'b1);

    // Randomized copies
    for (int n = 0; n < 4; n++) begin
      sz = $urandom_range(1, 700);
      l  = $urandom_range(1, 6);
      runCopy(sz, l, 1'($urandom_range(0, 1)) & (l >= 2), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/aes_cp_ctrl.md
# aes_cp_ctrl

Copy-engine sequencer between the APB-loaded InBuf SPSRAM, the AES core and the OutBuf SPSRAM. On a start pulse from the APB interface block, it processes the programmed byte count as 128-bit blocks: it reads 4 words from InBuf, hands the block to the AES core, waits for the result, then writes 4 words to OutBuf. When all blocks are done it pulses the copy-done flag, which feeds the interrupt pending logic.

## Interface
- `ADDR_W`, default 9: SPSRAM word address width.
- `SIZE_W`, default 12: byte-count width.
- `BLK_MAX`, default 128: maximum block count (512 words / 4).
- `iClk` input, 1: clock, rising edge.
- `iRsn` input, 1: reset, asynchronous, active-low.
- `iStCp` input, 1: start pulse, one cycle.
- `iCpByteSize` input, SIZE_W: byte count; sampled only on an accepted `iStCp`.
- `oCpDone` output, 1: one-cycle completion pulse.
- `oBusy` output, 1: high from the cycle after an accepted start through the DONE cycle.
- `oRdEn_InBuf` output, 1: InBuf read enable.
- `oRdAddr_InBuf` output, ADDR_W: InBuf word address.
- `iRdDt_InBuf` input, 32: InBuf read data; valid 1 cycle after `oRdEn_InBuf`.
- `oAesStart` output, 1: one-cycle request to the AES core.
- `oAesDt` output, 128: plaintext block; held stable from `oAesStart` until `iAesDone`.
- `iAesDone` input, 1: core result-valid pulse.
- `iAesDt` input, 128: core result; valid with `iAesDone`.
- `oWrEn_OutBuf` output, 1: OutBuf write enable.
- `oWrAddr_OutBuf` output, ADDR_W: OutBuf word address.
- `oWrDt_OutBuf` output, 32: OutBuf write data.

## Operation
- Block count: `N = (iCpByteSize + 15) >> 4`, computed at SIZE_W+1 bits and clamped to BLK_MAX. A partial final block is processed whole.
- Block k uses word addresses 4k..4k+3 in both buffers. Word 4k maps to bits [127:96] and word 4k+3 maps to bits [31:0].
- States:
  - IDLE: if `iStCp`, latch N and clear block index k. Go to DONE if N==0, otherwise go to RD.
  - RD (4 cycles, sub-count c=0..3): `oRdEn_InBuf`=1, `oRdAddr_InBuf`=4k+c. Capture word c-1 when c≥1.
  - CAP (1 cycle): capture word 3.
  - REQ (1 cycle): `oAesStart`=1.
  - WAIT: stay until `iAesDone`, then latch `iAesDt` into the result register.
  - WR (4 cycles, c=0..3): `oWrEn_OutBuf`=1, address 4k+c, data = result word c. On c=3, increment k; go to RD if k+1<N, otherwise go to DONE.
  - DONE (1 cycle): `oCpDone`=1, then go to IDLE.
- `iStCp` is ignored in every state except IDLE.
- `iAesDone` is ignored outside WAIT.
- The OutBuf port is shared with APB reads. The top level selects the controller's port while `oBusy`=1; software must poll `oBusy` or wait for the interrupt.

## Timing
- Reset (asynchronous assert, synchronous deassert via `iClk`):
  - State goes to IDLE; k, N and c are cleared.
  - All outputs are 0, including `oAesDt` and the address outputs.
  - A reset mid-operation abandons the copy with no `oCpDone`. OutBuf contents already written are left as they are.
- Start in cycle t (IDLE, `iStCp`=1): RD begins at t+1, and `oBusy` rises at t+1.
- Per block: 4 (RD) + 1 (CAP) + 1 (REQ) + L (WAIT, where `iAesDone` arrives L≥1 cycles after REQ) + 4 (WR) = 10+L cycles.
- Total: `oCpDone` is asserted at cycle t+1+N·(10+L). For N=0 it is asserted at t+1.
- `oBusy` falls in the cycle after DONE.
- `oAesDt` changes only in CAP.
- Output addresses, enables and data are registered, or decoded from registered state only. No input-to-output combinational path is allowed.

## Structure
- Shared package `aes_cp_pkg` holds:
  - the state enum (IDLE, RD, CAP, REQ, WAIT, WR, DONE);
  - the constants BLK_MAX, WORDS_PER_BLK=4 and BYTES_PER_BLK=16.
- The block is a single module with no sub-module. The 4-word pack and unpack is a shift register plus a word mux.

## Test plan
- Size 16, core latency L=3, InBuf[0..3]=0x00112233/44556677/8899AABB/CCDDEEFF:
  - `oAesDt`=0x00112233_44556677_8899AABB_CCDDEEFF.
  - Result written to OutBuf[0..3] in order.
  - `oCpDone` at t+14.
- Size 33: N=3. Addresses run 0..11 in both buffers, and exactly 3 `oAesStart` pulses occur.
- Size 0: `oCpDone` at t+1. No RAM enables and no `oAesStart`.
- Size 4095: N clamps to 128, and the last OutBuf write address is 511 (0x1FF).
- Start conditions:
  - `iStCp` during WAIT is ignored and the count is unchanged.
  - A stray `iAesDone` in IDLE or RD causes no state change.
- Reset mid-copy: `iRsn`=0 during the WR of block 1 of 3.
  - All outputs are 0 immediately, with no `oCpDone`.
  - A new start after reset then completes normally.
